// File: rtl/write_back_arbiter.sv
// Multi-channel writeback stage: per-lane result queues, round-robin commit to the
// register-file write port with matching scoreboard clear. Define WB_BYPASS_EN for 1-cycle bypass.
module write_back_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      wb_valid,
  output logic [NCH-1:0]      wb_ready,
  input  logic [NCH-1:0]      wb_reg_write,
  input  logic [NCH-1:0]      wb_mem_to_reg,
  input  logic [NCH*AW-1:0]   wb_rd,
  input  logic [NCH*XLEN-1:0] wb_alu_data,
  input  logic [NCH*XLEN-1:0] wb_dm_data,
  input  logic                stall_in,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [2**AW-1:0]    sb_clr,
  output logic                stall_flag_wb_out
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int RRW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW   = AW + XLEN;
  localparam int NREG = 2**AW;

  logic [EW-1:0]   mem      [NCH][DEPTH];
  logic [PTRW-1:0] rd_ptr   [NCH];
  logic [PTRW-1:0] wr_ptr   [NCH];
  logic [CNTW-1:0] count    [NCH];
  logic [EW-1:0]   in_entry [NCH];

  logic [NCH-1:0]  full;
  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  accept;
  logic [NCH-1:0]  storable;
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  req;
  logic [RRW-1:0]  rr_ptr;
  logic [RRW-1:0]  grant_idx;
  logic            grant_any;
  logic [EW-1:0]   grant_entry;

  assign wb_ready = reset ? ~full : '0;

  // Writes to r0 or with reg_write low are accepted but never stored.
  always_comb begin
    full     = '0;
    empty    = '0;
    accept   = '0;
    storable = '0;
    for (int c = 0; c < NCH; c++) begin
      full[c]     = (count[c] == CNTW'(DEPTH));
      empty[c]    = (count[c] == '0);
      accept[c]   = wb_valid[c] & wb_ready[c];
      storable[c] = accept[c] & wb_reg_write[c] & (wb_rd[c*AW +: AW] != '0);
      in_entry[c] = {wb_rd[c*AW +: AW],
                     wb_mem_to_reg[c] ? wb_dm_data[c*XLEN +: XLEN] : wb_alu_data[c*XLEN +: XLEN]};
    end
  end

`ifdef WB_BYPASS_EN
  // An empty queue with a storable arrival may compete and win directly.
  assign req = stall_in ? '0 : (~empty | storable);
`else
  assign req = stall_in ? '0 : ~empty;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_any && req[(int'(rr_ptr) + i) % NCH]) begin
        grant_any = 1'b1;
        grant_idx = RRW'((int'(rr_ptr) + i) % NCH);
      end
    end
  end

  always_comb begin
    pop         = '0;
    push        = storable;
    grant_entry = mem[grant_idx][rd_ptr[grant_idx]];
    if (grant_any) begin
`ifdef WB_BYPASS_EN
      if (empty[grant_idx]) begin
        push[grant_idx] = 1'b0;
        grant_entry     = in_entry[grant_idx];
      end else begin
        pop[grant_idx] = 1'b1;
      end
`else
      pop[grant_idx] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= in_entry[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
      rr_ptr            <= '0;
      rf_we             <= 1'b0;
      rf_waddr          <= '0;
      rf_wdata          <= '0;
      stall_flag_wb_out <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTRW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTRW'(1);
        if (push[c] && !pop[c])      count[c] <= count[c] + CNTW'(1);
        else if (pop[c] && !push[c]) count[c] <= count[c] - CNTW'(1);
      end
      stall_flag_wb_out <= |full;
      rf_we             <= grant_any;
      if (grant_any) begin
        rf_waddr <= grant_entry[EW-1 -: AW];
        rf_wdata <= grant_entry[XLEN-1:0];
        rr_ptr   <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + RRW'(1);
      end
    end
  end

  assign sb_clr = rf_we ? (NREG'(1) << rf_waddr) : '0;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Bench for write_back_arbiter (NCH=2, DEPTH=2): directed vector table, async reset
// sequence, then random traffic against a queue-based reference model.
module tb_write_back_arbiter;
  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [36:0] ent_t;
  typedef struct {
    logic [1:0]  v, rw, m2r;
    logic [4:0]  rd0, rd1;
    logic [31:0] a0, a1, d0, d1;
    logic        st;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_sf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_valid, wb_ready, wb_reg_write, wb_mem_to_reg;
  logic [9:0]  wb_rd;
  logic [63:0] wb_alu_data, wb_dm_data;
  logic        stall_in, rf_we, stall_flag_wb_out;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, sb_clr;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq [2][$];
  int          m_rr;
  logic        m_we, m_sf;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  vec_t tv [28];

  write_back_arbiter dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .wb_alu_data(wb_alu_data), .wb_dm_data(wb_dm_data), .stall_in(stall_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_clr(sb_clr),
    .stall_flag_wb_out(stall_flag_wb_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_ready();
    logic [1:0] r;
    r[0] = (mq[0].size() < DEPTH);
    r[1] = (mq[1].size() < DEPTH);
    return r;
  endfunction

  function automatic void model_reset();
    mq[0].delete();
    mq[1].delete();
    m_rr = 0; m_we = 1'b0; m_sf = 1'b0; m_addr = '0; m_data = '0;
  endfunction

  // One rising edge of the spec: accept, round-robin grant, commit, push.
  function automatic void model_edge(input logic [1:0] v, rw, m2r, input logic [4:0] r0, r1,
                                     input logic [31:0] a0, a1, d0, d1, input logic st);
    logic [4:0]  rd [2];
    logic [31:0] av [2];
    logic [31:0] dv [2];
    ent_t        e  [2];
    logic [1:0]  sto;
    logic        anyfull;
    int          g;
    ent_t        w;
    rd[0] = r0; rd[1] = r1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    anyfull = (mq[0].size() == DEPTH) || (mq[1].size() == DEPTH);
    for (int c = 0; c < 2; c++) begin
      sto[c] = v[c] && (mq[c].size() < DEPTH) && rw[c] && (rd[c] != 0);
      e[c]   = {rd[c], m2r[c] ? dv[c] : av[c]};
    end
    g = -1;
    if (!st) begin
      for (int i = 0; i < 2; i++) begin
        int c = (m_rr + i) % 2;
        if (g < 0 && (mq[c].size() > 0 || (BYP && sto[c]))) g = c;
      end
    end
    if (g >= 0) begin
      if (mq[g].size() > 0) w = mq[g].pop_front();
      else begin
        w = e[g];
        sto[g] = 1'b0;
      end
      m_we = 1'b1;
      m_addr = w[36:32];
      m_data = w[31:0];
      m_rr = (g + 1) % 2;
    end else begin
      m_we = 1'b0;
    end
    for (int c = 0; c < 2; c++) if (sto[c]) mq[c].push_back(e[c]);
    m_sf = anyfull;
  endfunction

  task automatic step(input logic [1:0] v, rw, m2r, input logic [4:0] r0, r1,
                      input logic [31:0] a0, a1, d0, d1, input logic st, output logic [1:0] rdy_seen);
    wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r;
    wb_rd = {r1, r0}; wb_alu_data = {a1, a0}; wb_dm_data = {d1, d0}; stall_in = st;
    #1;
    rdy_seen = wb_ready;
    chk("wb_ready", wb_ready, m_ready());
    @(posedge clk);
    model_edge(v, rw, m2r, r0, r1, a0, a1, d0, d1, st);
    @(negedge clk);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("sb_clr", sb_clr, m_we ? (32'd1 << m_addr) : 32'd0);
    chk("stall_flag", stall_flag_wb_out, m_sf);
  endtask

  function automatic vec_t mk(input logic [1:0] v, rw, m2r, input logic [4:0] rd0, rd1,
                              input logic [31:0] a0, a1, d1, input logic st,
                              input logic [1:0] erdy, input logic ewe, input logic [4:0] eaddr,
                              input logic [31:0] edata, input logic esf);
    vec_t t;
    t.v = v; t.rw = rw; t.m2r = m2r; t.rd0 = rd0; t.rd1 = rd1;
    t.a0 = a0; t.a1 = a1; t.d0 = ~a0; t.d1 = d1; t.st = st;
    t.e_rdy = erdy; t.e_we = ewe; t.e_addr = eaddr; t.e_data = edata; t.e_sf = esf;
    return t;
  endfunction

  function automatic vec_t idle(input logic [1:0] erdy, input logic ewe, input logic [4:0] eaddr,
                                input logic [31:0] edata, input logic esf);
    return mk(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, erdy, ewe, eaddr, edata, esf);
  endfunction

  initial begin
    logic [1:0] rdy;
    // single result, mem_to_reg, r0/no-write
    tv[0]  = mk(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 2'b11, 1'b0, 5'd0, 32'd0, 1'b0);
    tv[1]  = idle(2'b11, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tv[2]  = idle(2'b11, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tv[3]  = mk(2'b10, 2'b10, 2'b10, 5'd0, 5'd31, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 2'b11, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tv[4]  = idle(2'b11, 1'b1, 5'd31, 32'h1234_5678, 1'b0);
    tv[5]  = mk(2'b10, 2'b10, 2'b00, 5'd0, 5'd0, 32'd0, 32'h0000_AAAA, 32'd0, 1'b0, 2'b11, 1'b0, 5'd31, 32'h1234_5678, 1'b0);
    tv[6]  = mk(2'b10, 2'b00, 2'b00, 5'd0, 5'd7, 32'd0, 32'h0000_BBBB, 32'd0, 1'b0, 2'b11, 1'b0, 5'd31, 32'h1234_5678, 1'b0);
    tv[7]  = idle(2'b11, 1'b0, 5'd31, 32'h1234_5678, 1'b0);
    // stall for 5 cycles while ch0 pushes
    tv[8]  = mk(2'b01, 2'b01, 2'b00, 5'd20, 5'd0, 32'h100, 32'd0, 32'd0, 1'b1, 2'b11, 1'b0, 5'd31, 32'h1234_5678, 1'b0);
    tv[9]  = mk(2'b01, 2'b01, 2'b00, 5'd21, 5'd0, 32'h101, 32'd0, 32'd0, 1'b1, 2'b11, 1'b0, 5'd31, 32'h1234_5678, 1'b0);
    tv[10] = mk(2'b01, 2'b01, 2'b00, 5'd22, 5'd0, 32'h102, 32'd0, 32'd0, 1'b1, 2'b10, 1'b0, 5'd31, 32'h1234_5678, 1'b1);
    tv[11] = mk(2'b01, 2'b01, 2'b00, 5'd22, 5'd0, 32'h102, 32'd0, 32'd0, 1'b1, 2'b10, 1'b0, 5'd31, 32'h1234_5678, 1'b1);
    tv[12] = mk(2'b01, 2'b01, 2'b00, 5'd22, 5'd0, 32'h102, 32'd0, 32'd0, 1'b1, 2'b10, 1'b0, 5'd31, 32'h1234_5678, 1'b1);
    tv[13] = mk(2'b01, 2'b01, 2'b00, 5'd22, 5'd0, 32'h102, 32'd0, 32'd0, 1'b0, 2'b10, 1'b1, 5'd20, 32'h100, 1'b1);
    tv[14] = mk(2'b01, 2'b01, 2'b00, 5'd22, 5'd0, 32'h102, 32'd0, 32'd0, 1'b0, 2'b11, 1'b1, 5'd21, 32'h101, 1'b0);
    tv[15] = idle(2'b11, 1'b1, 5'd22, 32'h102, 1'b0);
    tv[16] = mk(2'b10, 2'b10, 2'b00, 5'd0, 5'd9, 32'd0, 32'h99, 32'd0, 1'b0, 2'b11, 1'b0, 5'd22, 32'h102, 1'b0);
    tv[17] = idle(2'b11, 1'b1, 5'd9, 32'h99, 1'b0);
    // contention: both channels push, commits alternate
    tv[18] = mk(2'b11, 2'b11, 2'b00, 5'd1, 5'd11, 32'hA000_0001, 32'hB000_000B, 32'd0, 1'b0, 2'b11, 1'b0, 5'd9, 32'h99, 1'b0);
    tv[19] = mk(2'b11, 2'b11, 2'b00, 5'd2, 5'd12, 32'hA000_0002, 32'hB000_000C, 32'd0, 1'b0, 2'b11, 1'b1, 5'd1, 32'hA000_0001, 1'b0);
    tv[20] = mk(2'b11, 2'b11, 2'b00, 5'd3, 5'd13, 32'hA000_0003, 32'hB000_000D, 32'd0, 1'b0, 2'b01, 1'b1, 5'd11, 32'hB000_000B, 1'b1);
    tv[21] = mk(2'b11, 2'b11, 2'b00, 5'd4, 5'd13, 32'hA000_0004, 32'hB000_000D, 32'd0, 1'b0, 2'b10, 1'b1, 5'd2, 32'hA000_0002, 1'b1);
    tv[22] = mk(2'b11, 2'b11, 2'b00, 5'd4, 5'd14, 32'hA000_0004, 32'hB000_000E, 32'd0, 1'b0, 2'b01, 1'b1, 5'd12, 32'hB000_000C, 1'b1);
    tv[23] = mk(2'b10, 2'b10, 2'b00, 5'd0, 5'd14, 32'd0, 32'hB000_000E, 32'd0, 1'b0, 2'b10, 1'b1, 5'd3, 32'hA000_0003, 1'b1);
    tv[24] = idle(2'b01, 1'b1, 5'd13, 32'hB000_000D, 1'b1);
    tv[25] = idle(2'b11, 1'b1, 5'd4, 32'hA000_0004, 1'b0);
    tv[26] = idle(2'b11, 1'b1, 5'd14, 32'hB000_000E, 1'b0);
    tv[27] = idle(2'b11, 1'b0, 5'd14, 32'hB000_000E, 1'b0);

    reset = 1'b0; wb_valid = '0; wb_reg_write = '0; wb_mem_to_reg = '0;
    wb_rd = '0; wb_alu_data = '0; wb_dm_data = '0; stall_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_ready", wb_ready, 2'b00);
    chk("reset_we", rf_we, 1'b0);
    reset = 1'b1;
    #1;

    for (int i = 0; i < 28; i++) begin
      step(tv[i].v, tv[i].rw, tv[i].m2r, tv[i].rd0, tv[i].rd1,
           tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1, tv[i].st, rdy);
`ifndef WB_BYPASS_EN
      chk($sformatf("tbl%0d_ready", i), rdy, tv[i].e_rdy);
      chk($sformatf("tbl%0d_we", i), rf_we, tv[i].e_we);
      chk($sformatf("tbl%0d_waddr", i), rf_waddr, tv[i].e_addr);
      chk($sformatf("tbl%0d_wdata", i), rf_wdata, tv[i].e_data);
      chk($sformatf("tbl%0d_sbclr", i), sb_clr, tv[i].e_we ? (32'd1 << tv[i].e_addr) : 32'd0);
      chk($sformatf("tbl%0d_sflag", i), stall_flag_wb_out, tv[i].e_sf);
`endif
    end

    // Reset mid-traffic: fill both queues, commit one, then pull reset between edges.
    step(2'b11, 2'b11, 2'b00, 5'd3, 5'd4, 32'h33, 32'h44, 32'd0, 32'd0, 1'b1, rdy);
    step(2'b11, 2'b11, 2'b00, 5'd6, 5'd8, 32'h66, 32'h88, 32'd0, 32'd0, 1'b1, rdy);
    step(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy);
    chk("pre_reset_we", rf_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_sbclr", sb_clr, 32'd0);
    chk("rst_sflag", stall_flag_wb_out, 1'b0);
    chk("rst_ready", wb_ready, 2'b00);
    model_reset();
    wb_valid = 2'b11; wb_reg_write = 2'b11; wb_rd = {5'd9, 5'd10};
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_we", rf_we, 1'b0);
    chk("rst_hold_ready", wb_ready, 2'b00);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", wb_ready, 2'b11);
    step(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy);
    step(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy);
    chk("no_stale_we", rf_we, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rw;
      rw[0] = ($urandom_range(0, 7) != 0);
      rw[1] = ($urandom_range(0, 7) != 0);
      step(2'($urandom), rw, 2'($urandom), 5'($urandom), 5'($urandom),
           $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 4) == 0), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/write_back_arbiter.md
# write_back_arbiter

Parametrised multi-channel writeback stage, successor to the single-lane writeback. It accepts completed results from NCH execution/memory lanes through per-lane valid/ready queues and selects ALU or memory data per entry. One result per cycle commits to the register-file write port, chosen by round-robin, and the matching scoreboard busy bit is cleared. It sits between the EX/MEM pipeline registers and the global register file/scoreboard.

## Interface
- XLEN, 32, data width
- AW, 5, register address width; register count is 2**AW
- NCH, 2, number of writeback channels (1..8)
- DEPTH, 2, per-channel queue depth (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  NCH  channel c presents a result
- wb_ready  out  NCH  channel c can accept; equals !full[c]; 0 while reset is low
- wb_reg_write  in  NCH  result targets a register
- wb_mem_to_reg  in  NCH  1 selects dm_data, 0 selects alu_data
- wb_rd  in  NCH*AW  destination register, channel c at [c*AW +: AW]
- wb_alu_data  in  NCH*XLEN  ALU result per channel
- wb_dm_data  in  NCH*XLEN  data-memory result per channel
- stall_in  in  1  freezes commit when high
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- sb_clr  out  2**AW  one-hot scoreboard busy-bit clear, aligned with rf_we
- stall_flag_wb_out  out  1  high when any channel queue is full (registered)

## Operation
- Accept on channel c at a rising edge when wb_valid[c] && wb_ready[c].
- At accept, data is muxed (mem_to_reg ? dm_data : alu_data), and {rd, data} is pushed into queue c.
- Entries with wb_reg_write=0 or wb_rd=0 are accepted but not stored; register 0 is never written and its sb_clr bit is never set.
- Each queue is a circular buffer with AW-independent pointers plus a count. full = (count==DEPTH), empty = (count==0). A pop from a full queue and a push in the same cycle are both permitted; the pointers wrap modulo DEPTH.
- Arbiter: if stall_in=0, it grants the first non-empty queue searching from rr_ptr upward, mod NCH. When channel k is granted, the head of k pops, the commit register loads {1, rd, data}, and rr_ptr becomes (k+1) mod NCH.
- If no grant occurs (all queues empty or stall_in=1), rf_we=0 next cycle, sb_clr=0, and rf_waddr/rf_wdata hold their last values.
- sb_clr = rf_we ? (1 << rf_waddr) : 0.
- Ordering: entries within a channel commit in FIFO order. Across channels there is no ordering; the upstream scoreboard guarantees at most one in-flight writer per register.
- stall_flag_wb_out registers OR(full) each cycle.
- Reset (any time, including mid-operation): all queues are emptied, rr_ptr=0, and rf_we=0, rf_waddr=0, rf_wdata=0, sb_clr=0, stall_flag_wb_out=0. Queued results are discarded.

## Timing
- Base latency: a result accepted at edge N into an empty queue with no contention has rf_we=1 in the cycle after edge N+1.
- Throughput: one commit per cycle aggregate; each channel sustains one commit per cycle when it is the only requester.
- With stall_in held, queues keep accepting until full. wb_ready[c] drops combinationally from the count; it does not depend on wb_valid.
- stall_flag_wb_out lags full by one cycle.
- Commits only at rising edges. There is no negedge logic; the register file samples rf_we/rf_waddr/rf_wdata on its own rising edge.

## Configuration
- WB_BYPASS_EN defined: a result accepted at edge N, whose queue is empty and which would win arbitration that cycle (stall_in=0, and no non-empty queue precedes it from rr_ptr), loads the commit register directly at edge N without being stored. rf_we=1 the cycle after edge N, giving 1-cycle latency. rr_ptr updates as for a normal grant.
- WB_BYPASS_EN undefined: all accepted entries pass through the queue, giving 2-cycle latency.

## Test plan
- Reset: reset=0 mid-traffic with entries queued -> all outputs 0 immediately, wb_ready=0; after release, wb_ready=2'b11 and no stale commit.
- Single result: ch0 rd=5, mem_to_reg=0, alu=32'hDEAD_BEEF at edge N -> rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF, sb_clr=1<<5 after edge N+1 (edge N with WB_BYPASS_EN).
- Contention: both channels push every cycle for 4 cycles (ch0 rd=1..4, ch1 rd=11..14) -> commits alternate 1,11,2,12,…, and queues fill, dropping wb_ready as expected.
- Register 0 / no-write: ch1 rd=0 with reg_write=1, then rd=7 with reg_write=0 -> both accepted, no rf_we, sb_clr stays 0.
- Stall: stall_in=1 for 5 cycles while ch0 pushes 3 results -> ch0 wb_ready=0 after 2 accepts, stall_flag_wb_out=1 one cycle later; on release, commits occur in FIFO order on consecutive cycles.
- mem_to_reg: ch1 mem_to_reg=1, dm=32'h1234_5678, alu=32'hFFFF_FFFF, rd=31 -> rf_wdata=12345678, sb_clr bit 31 set.
